// File: rtl/shift_rows_pipe.sv
// Rijndael ShiftRows / InvShiftRows engine for NB = 4, 6 or 8 columns.
// Combinational row rotation feeds a valid/ready register pipeline.
module shift_rows_pipe #(
    parameter int NB         = 4,
    parameter int PIPE_DEPTH = 1,
    parameter int TAG_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [32*NB-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_mode_err,
    output logic               busy
);
    localparam int W    = 32 * NB;
    localparam int LAST = PIPE_DEPTH - 1;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
        $error("shift_rows_pipe: PIPE_DEPTH must be 1..4");
    end

    // Wide blocks skip offset 2 so rows 2 and 3 rotate by 3 and 4.
    function automatic int row_shift(input int r);
        return (NB == 8 && r >= 2) ? r + 1 : r;
    endfunction

    logic [W-1:0]          fwd;
    logic [W-1:0]          inv;
    logic [W-1:0]          perm;
    logic                  perm_err;

    logic [PIPE_DEPTH-1:0] vld;
    logic [PIPE_DEPTH-1:0] ld;
    logic [PIPE_DEPTH-1:0] err;
    logic [W-1:0]          dat [PIPE_DEPTH];
    logic [TAG_W-1:0]      tg  [PIPE_DEPTH];

    // Rotate each row left (forward) or right (inverse) by its offset.
    always_comb begin
        fwd = '0;
        inv = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                fwd[W-1-8*(4*c+r) -: 8] =
                    in_data[W-1-8*(4*((c+row_shift(r))%NB)+r) -: 8];
                inv[W-1-8*(4*c+r) -: 8] =
                    in_data[W-1-8*(4*((c+NB-row_shift(r))%NB)+r) -: 8];
            end
        end
    end

    // Select the permutation; pass-through and illegal keep the state as is.
    always_comb begin
        perm     = in_data;
        perm_err = 1'b0;
        unique case (in_mode)
            2'b00:   perm = fwd;
            2'b01:   perm = inv;
            2'b10:   perm = in_data;
            default: perm_err = 1'b1;
        endcase
    end

    // A stage may load if any stage at or after it is empty or the tail drains.
    always_comb begin : load_chain
        logic go;
        go = out_ready;
        ld = '0;
        for (int i = LAST; i >= 0; i--) begin
            go    = go || !vld[i];
            ld[i] = go;
        end
    end

    // Stage 0 captures the permuted beat; later stages shift it forward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            err <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                dat[i] <= '0;
                tg[i]  <= '0;
            end
        end else begin
            if (ld[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    dat[0] <= perm;
                    tg[0]  <= in_tag;
                    err[0] <= perm_err;
                end
            end
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                if (ld[i]) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        dat[i] <= dat[i-1];
                        tg[i]  <= tg[i-1];
                        err[i] <= err[i-1];
                    end
                end
            end
        end
    end

    assign in_ready     = ld[0];
    assign out_valid    = vld[LAST];
    assign out_data     = dat[LAST];
    assign out_tag      = tg[LAST];
    assign out_mode_err = err[LAST];
    assign busy         = |vld;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: three configurations share one stimulus
// stream and are each checked against a queue-based reference model.
module tb_shift_rows_pipe;
    localparam int ND = 3;

    typedef struct {
        logic [255:0] d;
        logic [3:0]   t;
        logic         e;
        int           at;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [1:0]   in_mode;
    logic [3:0]   in_tag;
    logic [255:0] in_data;

    logic         rdy_a, rdy_b, rdy_c;
    logic         ov_a, ov_b, ov_c;
    logic         er_a, er_b, er_c;
    logic         bz_a, bz_b, bz_c;
    logic [3:0]   ot_a, ot_b, ot_c;
    logic [127:0] od_a;
    logic [255:0] od_b;
    logic [191:0] od_c;

    logic [ND-1:0] rdy, ov, er, bz;
    logic [255:0]  od [ND];
    logic [3:0]    ot [ND];

    beat_t         sb [ND][$];
    logic [ND-1:0] stall;
    logic [255:0]  hd [ND];
    logic [3:0]    ht [ND];
    logic          he [ND];

    int n_chk = 0;
    int n_fail = 0;
    int edges = 0;

    logic [255:0] x, y, v;

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(4), .PIPE_DEPTH(1), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy_a),
        .in_mode(in_mode), .in_tag(in_tag), .in_data(in_data[127:0]),
        .out_valid(ov_a), .out_ready(out_ready),
        .out_data(od_a), .out_tag(ot_a),
        .out_mode_err(er_a), .busy(bz_a)
    );

    shift_rows_pipe #(.NB(8), .PIPE_DEPTH(2), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy_b),
        .in_mode(in_mode), .in_tag(in_tag), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready),
        .out_data(od_b), .out_tag(ot_b),
        .out_mode_err(er_b), .busy(bz_b)
    );

    shift_rows_pipe #(.NB(6), .PIPE_DEPTH(3), .TAG_W(4)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy_c),
        .in_mode(in_mode), .in_tag(in_tag), .in_data(in_data[191:0]),
        .out_valid(ov_c), .out_ready(out_ready),
        .out_data(od_c), .out_tag(ot_c),
        .out_mode_err(er_c), .busy(bz_c)
    );

    assign rdy   = {rdy_c, rdy_b, rdy_a};
    assign ov    = {ov_c, ov_b, ov_a};
    assign er    = {er_c, er_b, er_a};
    assign bz    = {bz_c, bz_b, bz_a};
    assign od[0] = {128'b0, od_a};
    assign od[1] = od_b;
    assign od[2] = {64'b0, od_c};
    assign ot[0] = ot_a;
    assign ot[1] = ot_b;
    assign ot[2] = ot_c;

    function automatic int nb_of(input int k);
        case (k)
            0:       return 4;
            1:       return 8;
            default: return 6;
        endcase
    endfunction

    function automatic int pd_of(input int k);
        return k + 1;
    endfunction

    // State-matrix reference: row r rotated by its offset within nb columns.
    function automatic logic [255:0] ref_perm(input int nb,
                                              input logic [1:0] mode,
                                              input logic [255:0] d);
        logic [7:0]   st [4][8];
        logic [255:0] o;
        int           sh [4];
        int           w;
        int           src;
        w  = 32 * nb;
        sh = '{0, 1, 2, 3};
        if (nb == 8) sh = '{0, 1, 3, 4};
        o = '0;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = 8'h00;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = d[w-1-8*(4*c+r) -: 8];
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                case (mode)
                    2'b00:   src = (c + sh[r]) % nb;
                    2'b01:   src = (c - sh[r] + nb) % nb;
                    default: src = c;
                endcase
                o[w-1-8*(4*c+r) -: 8] = st[r][src];
            end
        end
        return o;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Front beat reaches the output stage PIPE_DEPTH-1 edges after capture.
    function automatic logic vis(input int k);
        if (sb[k].size() == 0) return 1'b0;
        return edges >= sb[k][0].at + pd_of(k) - 1;
    endfunction

    task automatic chk(input string nm, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("%s_ov%0d", nm, k), 256'(ov[k]), 256'(0));
            chk($sformatf("%s_busy%0d", nm, k), 256'(bz[k]), 256'(0));
            chk($sformatf("%s_data%0d", nm, k), od[k], 256'(0));
            chk($sformatf("%s_tag%0d", nm, k), 256'(ot[k]), 256'(0));
            chk($sformatf("%s_err%0d", nm, k), 256'(er[k]), 256'(0));
        end
    endtask

    // One clock: check handshake state, score emits, record accepts.
    task automatic tick();
        beat_t b;
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("busy%0d", k), 256'(bz[k]),
                256'(sb[k].size() != 0));
            chk($sformatf("in_ready%0d", k), 256'(rdy[k]),
                256'(out_ready || sb[k].size() < pd_of(k)));
            chk($sformatf("out_valid%0d", k), 256'(ov[k]), 256'(vis(k)));
            if (stall[k]) begin
                chk($sformatf("hold_data%0d", k), od[k], hd[k]);
                chk($sformatf("hold_tag%0d", k), 256'(ot[k]), 256'(ht[k]));
                chk($sformatf("hold_err%0d", k), 256'(er[k]), 256'(he[k]));
            end
            if (ov[k] && out_ready && sb[k].size() != 0) begin
                b = sb[k].pop_front();
                chk($sformatf("out_data%0d", k), od[k], b.d);
                chk($sformatf("out_tag%0d", k), 256'(ot[k]), 256'(b.t));
                chk($sformatf("mode_err%0d", k), 256'(er[k]), 256'(b.e));
            end
            stall[k] = ov[k] && !out_ready;
            hd[k] = od[k];
            ht[k] = ot[k];
            he[k] = er[k];
            if (in_valid && rdy[k]) begin
                b.d  = ref_perm(nb_of(k), in_mode, in_data);
                b.t  = in_tag;
                b.e  = (in_mode == 2'b11);
                b.at = edges + 1;
                sb[k].push_back(b);
            end
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_mode   = 2'b00;
        in_tag    = 4'h0;
        in_data   = '0;
        stall     = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b1;
        @(negedge clk);
        #1;
        for (int k = 0; k < ND; k++)
            chk($sformatf("rdy_after_reset%0d", k), 256'(rdy[k]), 256'(1));

        // FIPS-197 round 1 forward and inverse on the 128-bit block.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_tag    = 4'h1;
        in_data   = {128'b0, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230};
        tick();
        in_valid = 1'b0;
        #1;
        chk("fips_fwd", 256'(od_a),
            256'(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5));
        chk("fips_fwd_ov", 256'(ov_a), 256'(1));
        chk("fips_fwd_err", 256'(er_a), 256'(0));
        in_valid = 1'b1;
        in_mode  = 2'b01;
        in_tag   = 4'h2;
        in_data  = {128'b0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
        tick();
        in_valid = 1'b0;
        #1;
        chk("fips_inv", 256'(od_a),
            256'(128'hd42711ae_e0bf98f1_b8b45de5_1e415230));
        repeat (3) tick();

        // 256-bit block: rows 2 and 3 rotate by 3 and 4.
        for (int k = 0; k < 32; k++) v[255-8*k -: 8] = 8'(k);
        in_valid = 1'b1;
        in_mode  = 2'b00;
        in_tag   = 4'h3;
        in_data  = v;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("nb8_fwd_word0", 256'(od_b[255:224]), 256'(32'h00050e13));
        y = od_b;
        in_valid = 1'b1;
        in_mode  = 2'b01;
        in_tag   = 4'h4;
        in_data  = y;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("nb8_inv_identity", od_b, v);
        repeat (4) tick();

        // Backpressure fills the pipes, then tags drain in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        for (int t = 1; t <= 3; t++) begin
            in_tag  = 4'(t);
            in_data = rnd256();
            tick();
        end
        tick();
        #1;
        chk("bp_in_ready_b", 256'(rdy_b), 256'(0));
        chk("bp_tag_b", 256'(ot_b), 256'(1));
        out_ready = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            #1;
            chk($sformatf("drain_ov_b%0d", t), 256'(ov_b), 256'(1));
            chk($sformatf("drain_tag_b%0d", t), 256'(ot_b), 256'(t));
            tick();
            in_valid = 1'b0;
        end
        repeat (5) tick();

        // Pass-through and illegal modes leave the state untouched.
        for (int m = 2; m <= 4; m++) begin
            x        = rnd256();
            in_valid = 1'b1;
            in_mode  = 2'(m == 4 ? 0 : m);
            in_tag   = 4'(m);
            in_data  = x;
            tick();
            in_valid = 1'b0;
            #1;
            if (m != 4)
                chk($sformatf("mode%0d_data", m), 256'(od_a),
                    256'(x[127:0]));
            chk($sformatf("mode%0d_err", m), 256'(er_a), 256'(m == 3));
        end
        repeat (4) tick();

        // Forward then inverse on random blocks must restore the input.
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x        = rnd256();
            in_valid = 1'b1;
            in_mode  = 2'b00;
            in_tag   = 4'($urandom);
            in_data  = x;
            tick();
            y        = {128'b0, od_a};
            in_mode  = 2'b01;
            in_data  = y;
            tick();
            chk("roundtrip", 256'(od_a), 256'(x[127:0]));
        end
        in_valid = 1'b0;
        repeat (4) tick();

        // Random traffic, first mostly draining, then mostly stalled.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 800; i++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ph == 0 ? ($urandom_range(0, 3) != 0)
                                    : ($urandom_range(0, 3) == 0);
                in_mode   = 2'($urandom_range(0, 3));
                in_tag    = 4'($urandom);
                in_data   = rnd256();
                tick();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();

        // Reset pulse mid-stream discards every in-flight beat.
        in_mode = 2'b00;
        for (int t = 1; t <= 4; t++) begin
            in_valid = 1'b1;
            in_tag   = 4'(t);
            in_data  = rnd256();
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        chk_idle("midreset");
        for (int k = 0; k < ND; k++) sb[k].delete();
        stall    = '0;
        in_valid = 1'b0;
        @(posedge clk);
        edges++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("rdy_after_pulse%0d", k), 256'(rdy[k]), 256'(1));
            chk($sformatf("ov_after_pulse%0d", k), 256'(ov[k]), 256'(0));
        end
        for (int t = 9; t <= 12; t++) begin
            in_valid = 1'b1;
            in_tag   = 4'(t);
            in_data  = rnd256();
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        for (int k = 0; k < ND; k++)
            chk($sformatf("final_empty%0d", k), 256'(sb[k].size()),
                256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised Rijndael ShiftRows / InvShiftRows engine with selectable direction per transaction, for block widths of 128, 192 or 256 bits.
- Valid/ready handshake with full backpressure; PIPE_DEPTH register stages; a sideband tag travels with each beat.
- Sits between the SubBytes/InvSubBytes and MixColumns/AddRoundKey stages of the round datapath, and serves both cipher and inverse cipher.

Parameters:
- NB, 4, state columns (4, 6 or 8 → data width W = 32*NB); any other value is a static configuration error.
- PIPE_DEPTH, 1, number of register stages (1..4); equals latency in cycles.
- TAG_W, 4, width of sideband tag carried alongside data.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat this cycle
- in_mode  in  2  00 forward ShiftRows, 01 InvShiftRows, 10 pass-through, 11 illegal
- in_tag  in  TAG_W  sideband, returned unchanged
- in_data  in  W  state, column-major; byte k = in_data[W-1-8k -: 8]; state[r][c] = byte 4c+r
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts
- out_data  out  W  permuted state, same byte ordering
- out_tag  out  TAG_W  tag of the beat on out_data
- out_mode_err  out  1  beat was issued with in_mode=11
- busy  out  1  OR of all stage valid bits

Behaviour:
- Row offsets s_r: for NB=4 and NB=6, s = {0,1,2,3}; for NB=8, s = {0,1,3,4}.
- Forward: out[r][c] = in[r][(c+s_r) mod NB].
- Inverse: out[r][c] = in[r][(c-s_r) mod NB].
- Pass-through and illegal mode: out = in. Illegal mode also sets out_mode_err=1 for that beat only.
- Permutation is combinational, placed ahead of stage 0. Stages 1..PIPE_DEPTH-1 are pure registers holding {valid, data, tag, err}.
- Transfer occurs when valid && ready on the same edge.
- Stage i loads when it is empty or its contents advance this cycle. The last stage advances when out_ready=1.
- in_ready = !stage0_valid || stage0 advances. in_ready may depend combinationally on out_ready.
- Latency: a beat accepted at edge t is presented on out_valid after edge t+PIPE_DEPTH-1, i.e. first visible the cycle after acceptance when PIPE_DEPTH=1.
- Throughput: one beat per cycle while out_ready=1 continuously; no bubbles.
- Stall: while out_valid && !out_ready, out_data, out_tag and out_mode_err are held stable. No beat is dropped or duplicated.
- Capacity: PIPE_DEPTH beats. With out_ready held low, in_ready drops only once all stages are full.
- Simultaneous accept and emit on a full pipe is permitted and keeps occupancy constant.
- in_mode and in_tag are sampled only on accept; changes while not accepted have no effect.
- in_valid=0: nothing is captured and the data registers need not change. No X propagation is permitted into valid bits.
- Reset (asynchronous, any time, including mid-stream): all stage valid bits = 0, out_valid=0, out_data=0, out_tag=0, out_mode_err=0, busy=0, in_ready=1 from the first cycle after deassertion. In-flight beats are discarded.
- Beat order is always preserved.

Test Plan:
- NB=4, PIPE_DEPTH=1, mode 00, in_data=d42711ae_e0bf98f1_b8b45de5_1e415230 (FIPS-197 round 1) → out_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5 one cycle later, out_mode_err=0.
- Same bench, mode 01, in_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5 → out_data=d42711ae_e0bf98f1_b8b45de5_1e415230. Also run 1000 random beats forward then inverse → identity.
- NB=8, mode 00, in_data bytes 00..1f ascending → first out word 00050e13 (row3 offset 4, row2 offset 3). Mode 01 on that result → bytes 00..1f.
- PIPE_DEPTH=2, out_ready=0, in_valid=1 with tags 1,2,3 → tags 1,2 accepted, in_ready=0 holding tag 3. Raise out_ready → out_tag sequence 1,2,3 on consecutive cycles; out_data stable during the stall.
- Mode 10 and mode 11 with random data → out_data equals in_data. out_mode_err=0 for mode 10 and 1 for mode 11, only on that beat.
- PIPE_DEPTH=3, continuous stream of 8 beats, pulse rst low mid-stream for one cycle → out_valid=0 and busy=0 immediately, in_ready=1 after release, no pre-reset tag appears afterwards.
